instr_sequencer: RTL and testbench

Multi-cycle decode and sequencing stage directly upstream of the ALU/register-file datapath. Accepts one 32-bit MIPS-style instruction per handshake and decodes R-type and BEQ. Drives register read/write addresses, ALU control and write-back data to the datapath, then samples its Zero/ALUOut results. Reports completion, branch outcome, illegal opcodes and a retired-instruction count.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/instr_decode.sv | 46 ++++
 rtl/instr_sequencer.sv | 131 +++++++++++++
 tb/tb_instr_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer and its decoder.
package seq_pkg;

  // Sequencer phases; every instruction visits each phase for exactly one cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  // Opcodes the sequencer understands; everything else retires as illegal
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  // ALU operation classes presented to the datapath
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALU function codes used outside of R-type decode
  localparam logic [3:0] FUNC_NONE = 4'h0;
  localparam logic [3:0] FUNC_SUB  = 4'h2;

  // Register-file write enable encodings
  localparam logic [1:0] REGWRITE_EN  = 2'b01;
  localparam logic [1:0] REGWRITE_DIS = 2'b00;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and ALU control decode for one instruction word.
module instr_decode
  import seq_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [1:0]  alu_op,
  output logic [3:0]  func_code,
  output logic        is_rtype,
  output logic        is_beq,
  output logic        is_illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_bits;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];

  // Shift amount and the upper funct bits play no part in this ALU interface
  assign unused_bits = ^{ir[10:6], funct[5:4]};

  assign is_rtype   = (opcode == OPC_RTYPE);
  assign is_beq     = (opcode == OPC_BEQ);
  assign is_illegal = !(is_rtype || is_beq);

  // R-type takes its ALU function from funct, BEQ subtracts, illegal ops idle the ALU
  always_comb begin
    alu_op    = ALUOP_ADD;
    func_code = FUNC_NONE;
    if (is_rtype) begin
      alu_op    = ALUOP_FUNC;
      func_code = funct[3:0];
    end else if (is_beq) begin
      alu_op    = ALUOP_SUB;
      func_code = FUNC_SUB;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase decode/sequence stage: accepts an instruction, drives the datapath,
// captures its result and retires the instruction with status flags.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [1:0]       zero,
  input  logic [31:0]      alu_out,
  output logic [4:0]       read1,
  output logic [4:0]       read2,
  output logic [4:0]       write_reg,
  output logic [1:0]       reg_write,
  output logic [31:0]      write_data,
  output logic [3:0]       func_code,
  output logic [1:0]       alu_op,
  output logic             done,
  output logic             branch_taken,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_count
);

  state_t      state;
  logic [31:0] ir;
  logic [31:0] dec_word;
  logic        accept;
  logic        unused_zero;

  logic [4:0]  dec_rs;
  logic [4:0]  dec_rt;
  logic [4:0]  dec_rd;
  logic [1:0]  dec_alu_op;
  logic [3:0]  dec_func_code;
  logic        dec_is_rtype;
  logic        dec_is_beq;
  logic        dec_is_illegal;

  // Only bit 0 of the datapath Zero bus carries meaning
  assign unused_zero = zero[1];

  assign accept = instr_valid && instr_ready;

  // While idle the decoder looks at the incoming word so its fields can be
  // registered on the accept edge; afterwards it decodes the held instruction.
  assign dec_word = (state == IDLE) ? instr : ir;

  instr_decode u_decode (
    .ir         (dec_word),
    .rs         (dec_rs),
    .rt         (dec_rt),
    .rd         (dec_rd),
    .alu_op     (dec_alu_op),
    .func_code  (dec_func_code),
    .is_rtype   (dec_is_rtype),
    .is_beq     (dec_is_beq),
    .is_illegal (dec_is_illegal)
  );

  // Sequencer FSM with all datapath-facing outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ir           <= '0;
      instr_ready  <= 1'b1;
      read1        <= '0;
      read2        <= '0;
      write_reg    <= '0;
      reg_write    <= REGWRITE_DIS;
      write_data   <= '0;
      func_code    <= FUNC_NONE;
      alu_op       <= ALUOP_ADD;
      done         <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      retire_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ir          <= instr;
            read1       <= dec_rs;
            read2       <= dec_rt;
            write_reg   <= dec_rd;
            alu_op      <= dec_alu_op;
            func_code   <= dec_func_code;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          write_data   <= alu_out;
          done         <= 1'b1;
          reg_write    <= (dec_is_rtype && (dec_rd != 5'd0)) ? REGWRITE_EN : REGWRITE_DIS;
          branch_taken <= dec_is_beq && zero[0];
          illegal      <= dec_is_illegal;
          state        <= WB;
        end
        WB: begin
          if (!dec_is_illegal) begin
            retire_count <= retire_count + CNT_W'(1);
          end
          done         <= 1'b0;
          reg_write    <= REGWRITE_DIS;
          branch_taken <= 1'b0;
          illegal      <= 1'b0;
          alu_op       <= ALUOP_ADD;
          func_code    <= FUNC_NONE;
          instr_ready  <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          done         <= 1'b0;
          reg_write    <= REGWRITE_DIS;
          branch_taken <= 1'b0;
          illegal      <= 1'b0;
          instr_ready  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer, built with a 4-bit retire counter.
module tb_instr_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic [1:0]       zero;
  logic [31:0]      alu_out;
  logic [4:0]       read1;
  logic [4:0]       read2;
  logic [4:0]       write_reg;
  logic [1:0]       reg_write;
  logic [31:0]      write_data;
  logic [3:0]       func_code;
  logic [1:0]       alu_op;
  logic             done;
  logic             branch_taken;
  logic             illegal;
  logic [CNT_W-1:0] retire_count;

  always #5 clk = ~clk;

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .zero         (zero),
    .alu_out      (alu_out),
    .read1        (read1),
    .read2        (read2),
    .write_reg    (write_reg),
    .reg_write    (reg_write),
    .write_data   (write_data),
    .func_code    (func_code),
    .alu_op       (alu_op),
    .done         (done),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .retire_count (retire_count)
  );

  typedef struct {
    logic [31:0] wd;
    logic [1:0]  rw;
    logic        bt;
    logic        ill;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               fails  = 0;
  logic [CNT_W-1:0] expCount;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [31:0] wd, input logic [1:0] rw, input logic bt, input logic ill);
    exp_t e;
    e.wd = wd;
    e.rw = rw;
    e.bt = bt;
    e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic checkWb(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_has_entry"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_write_data"}, write_data, e.wd);
      checkOutput({tag, "_reg_write"}, 32'(reg_write), 32'(e.rw));
      checkOutput({tag, "_branch_taken"}, 32'(branch_taken), 32'(e.bt));
      checkOutput({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
      if (!e.ill) expCount = expCount + 1'b1;
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_ready"}, 32'(instr_ready), 32'd1);
  endtask

  task automatic waitDone(input string tag, output int n);
    n = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(n < 8), 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] w, input logic [31:0] av,
                               input logic [1:0] zv, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] wr, input logic [1:0] op, input logic [3:0] fc,
                               input logic [1:0] rw, input logic bt, input logic ill);
    int n;
    waitReady(tag);
    pushExp(av, rw, bt, ill);
    instr       = w;
    alu_out     = av;
    zero        = zv;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    checkOutput({tag, "_read1"}, 32'(read1), 32'(r1));
    checkOutput({tag, "_read2"}, 32'(read2), 32'(r2));
    checkOutput({tag, "_write_reg"}, 32'(write_reg), 32'(wr));
    checkOutput({tag, "_alu_op"}, 32'(alu_op), 32'(op));
    checkOutput({tag, "_func_code"}, 32'(func_code), 32'(fc));
    checkOutput({tag, "_busy"}, 32'(instr_ready), 32'd0);
    waitDone(tag, n);
    checkOutput({tag, "_latency"}, 32'(n), 32'd2);
    checkOutput({tag, "_alu_op_wb"}, 32'(alu_op), 32'(op));
    checkWb(tag);
    @(posedge clk); #1;
    checkOutput({tag, "_retire_count"}, 32'(retire_count), 32'(expCount));
    checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
    checkOutput({tag, "_reg_write_clear"}, 32'(reg_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int n;
    int k;
    int lowCount;
    logic r;

    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    zero        = 2'b00;
    alu_out     = '0;
    expCount    = '0;

    // Reset values
    #12;
    checkOutput("rst_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst_retire", 32'(retire_count), 32'd0);
    checkOutput("rst_write_data", write_data, 32'd0);
    checkOutput("rst_read1", 32'(read1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted while an R-type sits in WB
    @(posedge clk); #1;
    instr       = 32'h0022_1820;
    alu_out     = 32'h0000_000A;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    waitDone("midwb", n);
    checkOutput("midwb_reg_write_before", 32'(reg_write), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midwb_reg_write_async", 32'(reg_write), 32'd0);
    checkOutput("midwb_done_async", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midwb_ready_after", 32'(instr_ready), 32'd1);
    checkOutput("midwb_retire_after", 32'(retire_count), 32'd0);

    // add $3,$1,$2
    applyStimulus("add", 32'h0022_1820, 32'h0000_000A, 2'b00, 5'd1, 5'd2, 5'd3,
                  2'b10, 4'h0, 2'b01, 1'b0, 1'b0);
    // beq $4,$5 taken and not taken
    applyStimulus("beq_taken", 32'h1085_0003, 32'h0000_0000, 2'b01, 5'd4, 5'd5, 5'd0,
                  2'b01, 4'h2, 2'b00, 1'b1, 1'b0);
    applyStimulus("beq_not", 32'h1085_0003, 32'h0000_0007, 2'b00, 5'd4, 5'd5, 5'd0,
                  2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    // zero[1] alone must not count as a zero result
    applyStimulus("beq_z1only", 32'h1085_0003, 32'h0000_0003, 2'b10, 5'd4, 5'd5, 5'd0,
                  2'b01, 4'h2, 2'b00, 1'b0, 1'b0);
    // R-type writing r0 is suppressed but still retires
    applyStimulus("rd_zero", 32'h0022_0020, 32'h1234_5678, 2'b00, 5'd1, 5'd2, 5'd0,
                  2'b10, 4'h0, 2'b00, 1'b0, 1'b0);
    // R-type with a non-zero low funct nibble (sub = 0x22)
    applyStimulus("sub", 32'h00E6_2822, 32'hCAFE_0001, 2'b00, 5'd7, 5'd6, 5'd5,
                  2'b10, 4'h2, 2'b01, 1'b0, 1'b0);
    // Illegal opcode (lw) does not retire
    applyStimulus("illegal", 32'h8C22_0000, 32'hDEAD_BEEF, 2'b00, 5'd1, 5'd2, 5'd0,
                  2'b00, 4'h0, 2'b00, 1'b0, 1'b1);

    // Back-to-back: valid held high across two instructions
    waitReady("b2b");
    pushExp(32'h0000_0011, 2'b01, 1'b0, 1'b0);
    pushExp(32'h0000_0011, 2'b01, 1'b0, 1'b0);
    instr       = 32'h0022_1820;
    alu_out     = 32'h0000_0011;
    zero        = 2'b00;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr    = 32'h0022_2020;
    k        = 0;
    lowCount = 0;
    do begin
      @(negedge clk);
      r = instr_ready;
      if (!r) lowCount++;
      if (done) checkWb("b2b_first");
      @(posedge clk); #1;
      k++;
    end while (!r && k < 10);
    instr_valid = 1'b0;
    checkOutput("b2b_accept_gap", 32'(k), 32'd4);
    checkOutput("b2b_busy_cycles", 32'(lowCount), 32'd3);
    checkOutput("b2b_second_write_reg", 32'(write_reg), 32'd4);
    waitDone("b2b_second", n);
    checkWb("b2b_second");
    @(posedge clk); #1;
    checkOutput("b2b_retire", 32'(retire_count), 32'(expCount));

    // Counter wrap: 16 legal retirements from zero bring the 4-bit count back to 0
    rst = 1'b1;
    #3;
    sb.delete();
    expCount = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus("wrap", 32'h0022_1820, $urandom, 2'b00, 5'd1, 5'd2, 5'd3,
                    2'b10, 4'h0, 2'b01, 1'b0, 1'b0);
    end
    checkOutput("wrap_to_zero", 32'(retire_count), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
